// File: rtl/decode_stage_pkg.sv
// Shared decode constants and types for the RV32 ALU decode stage.
package decode_stage_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int REG_AW = 5;

    localparam logic [3:0] ALU_OP_ADD = 4'b0000;
    localparam logic [3:0] ALU_OP_SUB = 4'b0001;
    localparam logic [3:0] ALU_OP_MUL = 4'b0010;
    localparam logic [3:0] ALU_OP_AND = 4'b0011;
    localparam logic [3:0] ALU_OP_OR  = 4'b0100;
    localparam logic [3:0] ALU_OP_SLL = 4'b0101;
    localparam logic [3:0] ALU_OP_SRL = 4'b0110;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL     = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        B_RS2,
        B_IMM,
        B_SHAMT
    } b_sel_e;

    typedef struct packed {
        logic       illegal;
        logic [3:0] alu_op;
        b_sel_e     b_sel;
    } dec_t;

    function automatic dec_t legal(input logic [3:0] op, input b_sel_e sel);
        dec_t d;
        d.illegal = 1'b0;
        d.alu_op  = op;
        d.b_sel   = sel;
        return d;
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Register file: two async read ports, one sync write port, x0 reads zero.
module regfile_2r1w
    import decode_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/decode_stage.sv
// RV32 ALU-instruction decode stage: operand fetch, bypass, output register.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int NREG     = 32,
    parameter int ALU_OP_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_A,
    output logic [DATA_W-1:0]   out_B,
    output logic [ALU_OP_W-1:0] out_ALU_Op,
    output logic [4:0]          out_rd,
    output logic                out_illegal,
    input  logic                flush,
    input  logic                wb_en,
    input  logic [4:0]          wb_rd,
    input  logic [DATA_W-1:0]   wb_data
);

    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       is_op;
    logic       is_imm;
    logic       f7_zero;

    assign opc     = in_instr[6:0];
    assign f3      = in_instr[14:12];
    assign rs1     = in_instr[19:15];
    assign rs2     = in_instr[24:20];
    assign f7      = in_instr[31:25];
    assign is_op   = (opc == OPC_OP);
    assign is_imm  = (opc == OPC_OP_IMM);
    assign f7_zero = (f7 == F7_BASE);

    dec_t dec;

    always_comb begin
        dec.illegal = 1'b1;
        dec.alu_op  = ALU_OP_ADD;
        dec.b_sel   = B_RS2;
        unique case (1'b1)
            is_op && f3 == F3_ADD_SUB && f7_zero:
                dec = legal(ALU_OP_ADD, B_RS2);
            is_op && f3 == F3_ADD_SUB && f7 == F7_ALT:
                dec = legal(ALU_OP_SUB, B_RS2);
            is_op && f3 == F3_ADD_SUB && f7 == F7_MULDIV:
                dec = legal(ALU_OP_MUL, B_RS2);
            is_op && f3 == F3_AND && f7_zero:
                dec = legal(ALU_OP_AND, B_RS2);
            is_op && f3 == F3_OR && f7_zero:
                dec = legal(ALU_OP_OR, B_RS2);
            is_op && f3 == F3_SLL && f7_zero:
                dec = legal(ALU_OP_SLL, B_RS2);
            is_op && f3 == F3_SRL && f7_zero:
                dec = legal(ALU_OP_SRL, B_RS2);
            is_imm && f3 == F3_ADD_SUB:
                dec = legal(ALU_OP_ADD, B_IMM);
            is_imm && f3 == F3_AND:
                dec = legal(ALU_OP_AND, B_IMM);
            is_imm && f3 == F3_OR:
                dec = legal(ALU_OP_OR, B_IMM);
            is_imm && f3 == F3_SLL && f7_zero:
                dec = legal(ALU_OP_SLL, B_SHAMT);
            is_imm && f3 == F3_SRL && f7_zero:
                dec = legal(ALU_OP_SRL, B_SHAMT);
            default: ;
        endcase
    end

    logic [DATA_W-1:0] rf_rd1;
    logic [DATA_W-1:0] rf_rd2;

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1   (rs1),
        .ra2   (rs2),
        .rd1   (rf_rd1),
        .rd2   (rf_rd2),
        .we    (wb_en),
        .wa    (wb_rd),
        .wd    (wb_data)
    );

    // Same-cycle writeback forwarding; x0 never forwards.
    logic              wb_hit;
    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;

    assign wb_hit  = wb_en && (wb_rd != 5'd0);
    assign rs1_val = (wb_hit && wb_rd == rs1) ? wb_data : rf_rd1;
    assign rs2_val = (wb_hit && wb_rd == rs2) ? wb_data : rf_rd2;

    logic [DATA_W-1:0] imm_s;
    logic [DATA_W-1:0] imm_sh;
    logic [DATA_W-1:0] a_nxt;
    logic [DATA_W-1:0] b_nxt;
    logic [4:0]        rd_nxt;

    assign imm_s  = {{(DATA_W-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_sh = {{(DATA_W-5){1'b0}}, in_instr[24:20]};

    always_comb begin
        a_nxt  = '0;
        b_nxt  = '0;
        rd_nxt = '0;
        if (!dec.illegal) begin
            a_nxt  = rs1_val;
            rd_nxt = in_instr[11:7];
            unique case (dec.b_sel)
                B_IMM:   b_nxt = imm_s;
                B_SHAMT: b_nxt = imm_sh;
                default: b_nxt = rs2_val;
            endcase
        end
    end

    logic capture;

    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_A       <= '0;
            out_B       <= '0;
            out_ALU_Op  <= '0;
            out_rd      <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid   <= 1'b1;
            out_A       <= a_nxt;
            out_B       <= b_nxt;
            out_ALU_Op  <= dec.alu_op;
            out_rd      <= rd_nxt;
            out_illegal <= dec.illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: vector table through a scoreboard plus corner sequences.
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_A;
    logic [31:0] out_B;
    logic [3:0]  out_ALU_Op;
    logic [4:0]  out_rd;
    logic        out_illegal;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    decode_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_A       (out_A),
        .out_B       (out_B),
        .out_ALU_Op  (out_ALU_Op),
        .out_rd      (out_rd),
        .out_illegal (out_illegal),
        .flush       (flush),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        ill;
    } vec_t;

    vec_t q[$];
    vec_t vecs[18];
    int   tests = 0;
    int   fails = 0;

    // Scoreboard: every consumed beat must match the oldest expectation.
    always @(negedge clk) begin
        vec_t e;
        if (rst_n && out_valid && out_ready) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL beat: unexpected output rd=%0d A=%h", out_rd, out_A);
            end else begin
                e = q.pop_front();
                if (out_A !== e.a || out_B !== e.b || out_ALU_Op !== e.op ||
                    out_rd !== e.rd || out_illegal !== e.ill) begin
                    fails++;
                    $display("FAIL beat %h: got A=%h B=%h op=%h rd=%0d ill=%b, want A=%h B=%h op=%h rd=%0d ill=%b",
                             e.instr, out_A, out_B, out_ALU_Op, out_rd, out_illegal,
                             e.a, e.b, e.op, e.rd, e.ill);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
        wb_en   = 1'b1;
        wb_rd   = rd;
        wb_data = data;
        @(posedge clk);
        #1;
        wb_en = 1'b0;
    endtask

    task automatic issue(input vec_t v);
        bit ok;
        ok = 1'b0;
        q.push_back(v);
        in_valid = 1'b1;
        in_instr = v.instr;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL issue %h: in_ready stayed 0, want 1", v.instr);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wb_en    = 1'b0;
    endtask

    task automatic drain();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " out_A"}, out_A, 32'd0);
        chk({tag, " out_B"}, out_B, 32'd0);
        chk({tag, " out_ALU_Op"}, 32'(out_ALU_Op), 32'd0);
        chk({tag, " out_rd"}, 32'(out_rd), 32'd0);
        chk({tag, " out_illegal"}, 32'(out_illegal), 32'd0);
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{32'h002081B3, 32'd10, 32'd5, 4'b0000, 5'd3, 1'b0};
        vecs[1]  = '{32'h40208233, 32'd10, 32'd5, 4'b0001, 5'd4, 1'b0};
        vecs[2]  = '{32'h022082B3, 32'd10, 32'd5, 4'b0010, 5'd5, 1'b0};
        vecs[3]  = '{32'h0093F333, 32'h80000003, 32'hFFFFFFF0, 4'b0011, 5'd6, 1'b0};
        vecs[4]  = '{32'h0013E433, 32'h80000003, 32'd10, 4'b0100, 5'd8, 1'b0};
        vecs[5]  = '{32'h00209533, 32'd10, 32'd5, 4'b0101, 5'd10, 1'b0};
        vecs[6]  = '{32'h0024D5B3, 32'hFFFFFFF0, 32'd5, 4'b0110, 5'd11, 1'b0};
        vecs[7]  = '{32'hFFF00293, 32'd0, 32'hFFFFFFFF, 4'b0000, 5'd5, 1'b0};
        vecs[8]  = '{32'h7FF3F613, 32'h80000003, 32'h000007FF, 4'b0011, 5'd12, 1'b0};
        vecs[9]  = '{32'hFF00E693, 32'd10, 32'hFFFFFFF0, 4'b0100, 5'd13, 1'b0};
        vecs[10] = '{32'h01F09713, 32'd10, 32'd31, 4'b0101, 5'd14, 1'b0};
        vecs[11] = '{32'h0044D793, 32'hFFFFFFF0, 32'd4, 4'b0110, 5'd15, 1'b0};
        vecs[12] = '{32'h00000000, 32'd0, 32'd0, 4'b0000, 5'd0, 1'b1};
        vecs[13] = '{32'h41F09713, 32'd0, 32'd0, 4'b0000, 5'd0, 1'b1};
        vecs[14] = '{32'h04208233, 32'd0, 32'd0, 4'b0000, 5'd0, 1'b1};
        vecs[15] = '{32'h4093F333, 32'd0, 32'd0, 4'b0000, 5'd0, 1'b1};
        vecs[16] = '{32'h7FF10813, 32'd5, 32'h000007FF, 4'b0000, 5'd16, 1'b0};
        vecs[17] = '{32'h0000A183, 32'd0, 32'd0, 4'b0000, 5'd0, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 1'b1;
        flush     = 1'b0;
        wb_en     = 1'b0;
        wb_rd     = '0;
        wb_data   = '0;
        #12;
        chk_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        wb_write(5'd1, 32'd10);
        wb_write(5'd2, 32'd5);
        wb_write(5'd7, 32'h80000003);
        wb_write(5'd9, 32'hFFFFFFF0);

        for (int i = 0; i < 18; i++) begin
            issue(vecs[i]);
        end
        drain();

        // x0 ignores writes, and never forwards either.
        wb_write(5'd0, 32'd7);
        issue('{32'h000008B3, 32'd0, 32'd0, 4'b0000, 5'd17, 1'b0});
        wb_en   = 1'b1;
        wb_rd   = 5'd0;
        wb_data = 32'd7;
        issue('{32'h000008B3, 32'd0, 32'd0, 4'b0000, 5'd17, 1'b0});

        wb_en   = 1'b1;
        wb_rd   = 5'd1;
        wb_data = 32'h1234;
        issue('{32'h002081B3, 32'h1234, 32'd5, 4'b0000, 5'd3, 1'b0});
        issue('{32'h002081B3, 32'h1234, 32'd5, 4'b0000, 5'd3, 1'b0});
        drain();

        out_ready = 1'b0;
        issue('{32'h002081B3, 32'h1234, 32'd5, 4'b0000, 5'd3, 1'b0});
        in_valid = 1'b1;
        in_instr = 32'h40208233;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold in_ready", 32'(in_ready), 32'd0);
            chk("hold out_valid", 32'(out_valid), 32'd1);
            chk("hold out_A", out_A, 32'h1234);
            chk("hold out_rd", 32'(out_rd), 32'd3);
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush out_valid", 32'(out_valid), 32'd0);
        chk("flush in_ready", 32'(in_ready), 32'd1);
        void'(q.pop_front());
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Flush beats a same-cycle capture but not a same-cycle write.
        in_valid = 1'b1;
        in_instr = 32'h002081B3;
        flush    = 1'b1;
        wb_en    = 1'b1;
        wb_rd    = 5'd20;
        wb_data  = 32'hABCD;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        wb_en    = 1'b0;
        @(negedge clk);
        chk("flush drops capture", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        issue('{32'h000A0AB3, 32'hABCD, 32'd0, 4'b0000, 5'd21, 1'b0});
        drain();

        out_ready = 1'b0;
        issue('{32'h40208233, 32'h1234, 32'd5, 4'b0001, 5'd4, 1'b0});
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        q.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        issue('{32'h002081B3, 32'd0, 32'd0, 4'b0000, 5'd3, 1'b0});
        drain();

        chk("scoreboard empty", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
